// File: rtl/mem_access_ls.sv
// Memory-access pipeline stage: passes ALU results to writeback and runs LW/SW/LM/SM
// against a request/grant/response data-memory port, stalling upstream while busy.
//
//   state  | meaning
//   IDLE   | accept a new instruction; non-memory ops retire next cycle
//   REQ    | dm_req held with stable address/data until dm_gnt
//   RESP   | load issued and granted, waiting for dm_rvalid
module mem_access_ls #(
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 16,
    parameter int unsigned RW    = 3,
    parameter int unsigned OPW   = 4,
    parameter int unsigned OP_LW = 4,
    parameter int unsigned OP_SW = 5,
    parameter int unsigned OP_LM = 6,
    parameter int unsigned OP_SM = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    input  logic [OPW-1:0]       in_opcode,
    input  logic [AW-1:0]        in_addr,
    input  logic [DW-1:0]        in_store_data,
    input  logic [RW-1:0]        in_rc_addr,
    input  logic [DW-1:0]        in_rc_data,
    input  logic                 in_rc_w_valid,
    input  logic [(2**RW)-1:0]   in_mask,
    output logic [RW-1:0]        sm_rd_addr,
    input  logic [DW-1:0]        sm_rd_data,
    output logic                 dm_req,
    output logic                 dm_we,
    output logic [AW-1:0]        dm_addr,
    output logic [DW-1:0]        dm_wdata,
    input  logic                 dm_gnt,
    input  logic                 dm_rvalid,
    input  logic [DW-1:0]        dm_rdata,
    output logic                 wb_valid,
    output logic [OPW-1:0]       wb_opcode,
    output logic [RW-1:0]        wb_rc_addr,
    output logic [DW-1:0]        wb_rc_data,
    output logic                 wb_rc_w_valid
);

    localparam int NREG = 2**RW;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
    typedef enum logic [1:0] {K_LW, K_SW, K_LM, K_SM} kind_t;

    state_t            state_q, state_d;
    kind_t             kind_q, kind_d;
    logic [OPW-1:0]    opcode_q, opcode_d;
    logic [RW-1:0]     rc_addr_q, rc_addr_d;
    logic              rc_w_valid_q, rc_w_valid_d;
    logic [AW-1:0]     base_q, base_d;
    logic [AW-1:0]     offset_q, offset_d;
    logic [NREG-1:0]   mask_q, mask_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic [OPW-1:0]    wb_opcode_q, wb_opcode_d;
    logic [RW-1:0]     wb_rc_addr_q, wb_rc_addr_d;
    logic [DW-1:0]     wb_rc_data_q, wb_rc_data_d;
    logic              wb_rc_w_valid_q, wb_rc_w_valid_d;

    logic [RW-1:0]     idx;
    logic [NREG-1:0]   mask_rest;
    logic              is_mem_single;
    logic              is_mem_multi;

    // Lowest set mask bit is the register serviced by the current LM/SM transfer.
    always_comb begin
        idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (mask_q[i]) idx = RW'(i);
        end
    end

    assign mask_rest = mask_q & (mask_q - NREG'(1));

    assign is_mem_single = (in_opcode == OPW'(OP_LW)) || (in_opcode == OPW'(OP_SW));
    assign is_mem_multi  = (in_opcode == OPW'(OP_LM)) || (in_opcode == OPW'(OP_SM));

    assign in_ready   = (state_q == S_IDLE);
    assign dm_req     = (state_q == S_REQ);
    assign dm_we      = dm_req && (kind_q == K_SW || kind_q == K_SM);
    assign dm_addr    = dm_req ? (base_q + offset_q) : '0;
    assign sm_rd_addr = (dm_req && kind_q == K_SM) ? idx : '0;

    always_comb begin
        dm_wdata = '0;
        if (dm_req && kind_q == K_SM) dm_wdata = sm_rd_data;
        else if (dm_req && kind_q == K_SW) dm_wdata = wdata_q;
    end

    always_comb begin
        state_d         = state_q;
        kind_d          = kind_q;
        opcode_d        = opcode_q;
        rc_addr_d       = rc_addr_q;
        rc_w_valid_d    = rc_w_valid_q;
        base_d          = base_q;
        offset_d        = offset_q;
        mask_d          = mask_q;
        wdata_d         = wdata_q;
        wb_valid_d      = 1'b0;
        wb_opcode_d     = '0;
        wb_rc_addr_d    = '0;
        wb_rc_data_d    = '0;
        wb_rc_w_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    if (is_mem_single) begin
                        kind_d       = (in_opcode == OPW'(OP_LW)) ? K_LW : K_SW;
                        opcode_d     = in_opcode;
                        rc_addr_d    = in_rc_addr;
                        rc_w_valid_d = in_rc_w_valid;
                        base_d       = in_addr;
                        offset_d     = '0;
                        wdata_d      = in_store_data;
                        state_d      = S_REQ;
                    end else if (is_mem_multi) begin
                        kind_d   = (in_opcode == OPW'(OP_LM)) ? K_LM : K_SM;
                        opcode_d = in_opcode;
                        base_d   = in_addr;
                        offset_d = '0;
                        mask_d   = in_mask;
                        if (in_mask == '0) begin
                            wb_valid_d  = 1'b1;
                            wb_opcode_d = in_opcode;
                        end else begin
                            state_d = S_REQ;
                        end
                    end else begin
                        wb_valid_d      = 1'b1;
                        wb_opcode_d     = in_opcode;
                        wb_rc_addr_d    = in_rc_addr;
                        wb_rc_data_d    = in_rc_data;
                        wb_rc_w_valid_d = in_rc_w_valid;
                    end
                end
            end
            S_REQ: begin
                if (dm_gnt) begin
                    case (kind_q)
                        K_LW, K_LM: state_d = S_RESP;
                        K_SW: begin
                            wb_valid_d   = 1'b1;
                            wb_opcode_d  = opcode_q;
                            wb_rc_addr_d = rc_addr_q;
                            state_d      = S_IDLE;
                        end
                        default: begin
                            mask_d   = mask_rest;
                            offset_d = offset_q + AW'(1);
                            // Only the final SM transfer produces a writeback slot.
                            if (mask_rest == '0) begin
                                wb_valid_d  = 1'b1;
                                wb_opcode_d = opcode_q;
                                state_d     = S_IDLE;
                            end
                        end
                    endcase
                end
            end
            S_RESP: begin
                if (dm_rvalid) begin
                    wb_valid_d   = 1'b1;
                    wb_opcode_d  = opcode_q;
                    wb_rc_data_d = dm_rdata;
                    if (kind_q == K_LM) begin
                        wb_rc_addr_d    = idx;
                        wb_rc_w_valid_d = 1'b1;
                        mask_d          = mask_rest;
                        offset_d        = offset_q + AW'(1);
                        state_d         = (mask_rest != '0) ? S_REQ : S_IDLE;
                    end else begin
                        wb_rc_addr_d    = rc_addr_q;
                        wb_rc_w_valid_d = rc_w_valid_q;
                        state_d         = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            kind_q          <= K_LW;
            opcode_q        <= '0;
            rc_addr_q       <= '0;
            rc_w_valid_q    <= 1'b0;
            base_q          <= '0;
            offset_q        <= '0;
            mask_q          <= '0;
            wdata_q         <= '0;
            wb_valid_q      <= 1'b0;
            wb_opcode_q     <= '0;
            wb_rc_addr_q    <= '0;
            wb_rc_data_q    <= '0;
            wb_rc_w_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            kind_q          <= kind_d;
            opcode_q        <= opcode_d;
            rc_addr_q       <= rc_addr_d;
            rc_w_valid_q    <= rc_w_valid_d;
            base_q          <= base_d;
            offset_q        <= offset_d;
            mask_q          <= mask_d;
            wdata_q         <= wdata_d;
            wb_valid_q      <= wb_valid_d;
            wb_opcode_q     <= wb_opcode_d;
            wb_rc_addr_q    <= wb_rc_addr_d;
            wb_rc_data_q    <= wb_rc_data_d;
            wb_rc_w_valid_q <= wb_rc_w_valid_d;
        end
    end

    assign wb_valid      = wb_valid_q;
    assign wb_opcode     = wb_opcode_q;
    assign wb_rc_addr    = wb_rc_addr_q;
    assign wb_rc_data    = wb_rc_data_q;
    assign wb_rc_w_valid = wb_rc_w_valid_q;

endmodule

// File: tb/tb_mem_access_ls.sv
// Directed bench for mem_access_ls: inputs change 1 time unit after the rising edge,
// outputs are checked on the falling edge against hand-computed values.
module tb_mem_access_ls;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [3:0]  in_opcode;
    logic [15:0] in_addr;
    logic [15:0] in_store_data;
    logic [2:0]  in_rc_addr;
    logic [15:0] in_rc_data;
    logic        in_rc_w_valid;
    logic [7:0]  in_mask;
    logic [2:0]  sm_rd_addr;
    logic [15:0] sm_rd_data;
    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [15:0] dm_rdata;
    logic        wb_valid;
    logic [3:0]  wb_opcode;
    logic [2:0]  wb_rc_addr;
    logic [15:0] wb_rc_data;
    logic        wb_rc_w_valid;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Register file model: R[n] = 0xA000 + n.
    assign sm_rd_data = 16'hA000 | {13'b0, sm_rd_addr};

    mem_access_ls dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .in_opcode(in_opcode), .in_addr(in_addr), .in_store_data(in_store_data),
        .in_rc_addr(in_rc_addr), .in_rc_data(in_rc_data), .in_rc_w_valid(in_rc_w_valid),
        .in_mask(in_mask),
        .sm_rd_addr(sm_rd_addr), .sm_rd_data(sm_rd_data),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .wb_valid(wb_valid), .wb_opcode(wb_opcode), .wb_rc_addr(wb_rc_addr),
        .wb_rc_data(wb_rc_data), .wb_rc_w_valid(wb_rc_w_valid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; flush = 0; in_opcode = 0; in_addr = 0; in_store_data = 0;
        in_rc_addr = 0; in_rc_data = 0; in_rc_w_valid = 0; in_mask = 0;
        dm_gnt = 0; dm_rvalid = 0; dm_rdata = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b exp=1", in_ready); else passed++;
        total++; if (dm_req !== 1'b0) $display("FAIL reset_dm_req got=%0b exp=0", dm_req); else passed++;
        total++; if ({wb_valid, wb_opcode, wb_rc_addr, wb_rc_data, wb_rc_w_valid} !== '0)
            $display("FAIL reset_wb got=%h exp=0", {wb_valid, wb_opcode, wb_rc_addr, wb_rc_data, wb_rc_w_valid}); else passed++;
        total++; if ({dm_we, dm_addr, dm_wdata} !== '0)
            $display("FAIL reset_dm_fields got=%h exp=0", {dm_we, dm_addr, dm_wdata}); else passed++;
        rst = 1;
        step();
        @(negedge clk);
        total++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); else passed++;
        step();
    endtask

    task automatic test_alu_passthrough();
        in_valid = 1; in_opcode = 4'd1; in_rc_addr = 3'd3; in_rc_data = 16'h1234; in_rc_w_valid = 1;
        @(negedge clk);
        total++; if (wb_valid !== 1'b0) $display("FAIL alu_pre_wb_valid got=%0b exp=0", wb_valid); else passed++;
        step();
        in_rc_data = 16'h5678;
        @(negedge clk);
        total++; if (wb_valid !== 1'b1) $display("FAIL alu1_wb_valid got=%0b exp=1", wb_valid); else passed++;
        total++; if ({wb_opcode, wb_rc_addr, wb_rc_data, wb_rc_w_valid} !== {4'd1, 3'd3, 16'h1234, 1'b1})
            $display("FAIL alu1_fields got=%h/%h/%h/%b exp=1/3/1234/1", wb_opcode, wb_rc_addr, wb_rc_data, wb_rc_w_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL alu_in_ready got=%0b exp=1", in_ready); else passed++;
        step();
        in_valid = 0;
        @(negedge clk);
        total++; if (wb_valid !== 1'b1) $display("FAIL alu2_wb_valid got=%0b exp=1", wb_valid); else passed++;
        total++; if (wb_rc_data !== 16'h5678) $display("FAIL alu2_data got=%h exp=5678", wb_rc_data); else passed++;
        step();
        @(negedge clk);
        total++; if ({wb_valid, wb_opcode, wb_rc_addr, wb_rc_data, wb_rc_w_valid} !== '0)
            $display("FAIL alu_idle_wb got=%h exp=0", {wb_valid, wb_opcode, wb_rc_addr, wb_rc_data, wb_rc_w_valid}); else passed++;
        idle_inputs();
    endtask

    task automatic test_lw();
        in_valid = 1; in_opcode = 4'd4; in_addr = 16'h0010; in_rc_addr = 3'd2; in_rc_w_valid = 1;
        step();
        in_valid = 0; in_addr = 16'h9999;
        for (int k = 0; k < 3; k++) begin
            dm_gnt = (k == 2);
            dm_rvalid = (k == 0); dm_rdata = 16'hDEAD;
            @(negedge clk);
            total++; if ({dm_req, dm_we, dm_addr} !== {1'b1, 1'b0, 16'h0010})
                $display("FAIL lw_req_c%0d got req=%b we=%b addr=%h exp 1/0/0010", k, dm_req, dm_we, dm_addr); else passed++;
            total++; if ({in_ready, wb_valid} !== 2'b00)
                $display("FAIL lw_busy_c%0d got ready=%b wb=%b exp 0/0", k, in_ready, wb_valid); else passed++;
            step();
        end
        dm_gnt = 1; dm_rvalid = 0;
        @(negedge clk);
        total++; if ({dm_req, in_ready, wb_valid} !== 3'b000)
            $display("FAIL lw_resp_wait got req=%b ready=%b wb=%b exp 0/0/0", dm_req, in_ready, wb_valid); else passed++;
        step();
        dm_gnt = 0; dm_rvalid = 1; dm_rdata = 16'hBEEF;
        step();
        dm_rvalid = 0; dm_rdata = 0;
        @(negedge clk);
        total++; if ({wb_valid, wb_opcode, wb_rc_addr, wb_rc_data, wb_rc_w_valid} !== {1'b1, 4'd4, 3'd2, 16'hBEEF, 1'b1})
            $display("FAIL lw_wb got v=%b op=%h rc=%h d=%h w=%b exp 1/4/2/BEEF/1", wb_valid, wb_opcode, wb_rc_addr, wb_rc_data, wb_rc_w_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL lw_done_ready got=%0b exp=1", in_ready); else passed++;
        step();
        @(negedge clk);
        total++; if (wb_valid !== 1'b0) $display("FAIL lw_single_wb got=%0b exp=0", wb_valid); else passed++;
        idle_inputs();
    endtask

    task automatic test_sw();
        in_valid = 1; in_opcode = 4'd5; in_addr = 16'h0020; in_store_data = 16'h55AA;
        in_rc_addr = 3'd4; in_rc_w_valid = 1;
        step();
        in_valid = 0; in_addr = 0; in_store_data = 0;
        for (int k = 0; k < 2; k++) begin
            dm_gnt = (k == 1);
            @(negedge clk);
            total++; if ({dm_req, dm_we, dm_addr, dm_wdata} !== {1'b1, 1'b1, 16'h0020, 16'h55AA})
                $display("FAIL sw_req_c%0d got req=%b we=%b addr=%h wd=%h exp 1/1/0020/55AA", k, dm_req, dm_we, dm_addr, dm_wdata); else passed++;
            total++; if (in_ready !== 1'b0) $display("FAIL sw_busy_c%0d got=%0b exp=0", k, in_ready); else passed++;
            step();
        end
        dm_gnt = 0;
        @(negedge clk);
        total++; if ({wb_valid, wb_opcode, wb_rc_w_valid} !== {1'b1, 4'd5, 1'b0})
            $display("FAIL sw_wb got v=%b op=%h w=%b exp 1/5/0", wb_valid, wb_opcode, wb_rc_w_valid); else passed++;
        total++; if ({dm_req, in_ready} !== 2'b01) $display("FAIL sw_done got req=%b ready=%b exp 0/1", dm_req, in_ready); else passed++;
        idle_inputs();
        step();
    endtask

    task automatic test_lm_wrap();
        logic [2:0]  exp_idx [3];
        logic [15:0] exp_addr [3];
        logic [15:0] rd [3];
        exp_idx  = '{3'd0, 3'd5, 3'd7};
        exp_addr = '{16'hFFFF, 16'h0000, 16'h0001};
        rd       = '{16'h1111, 16'h2222, 16'h3333};
        in_valid = 1; in_opcode = 4'd6; in_addr = 16'hFFFF; in_mask = 8'b1010_0001;
        step();
        in_valid = 0; in_mask = 0; in_addr = 0;
        for (int k = 0; k < 3; k++) begin
            dm_gnt = 1; dm_rvalid = 0;
            @(negedge clk);
            total++; if ({dm_req, dm_we, dm_addr} !== {1'b1, 1'b0, exp_addr[k]})
                $display("FAIL lm_req_%0d got req=%b we=%b addr=%h exp 1/0/%h", k, dm_req, dm_we, dm_addr, exp_addr[k]); else passed++;
            if (k > 0) begin
                total++; if ({wb_valid, wb_rc_addr, wb_rc_data, wb_rc_w_valid} !== {1'b1, exp_idx[k-1], rd[k-1], 1'b1})
                    $display("FAIL lm_wb_%0d got v=%b rc=%h d=%h w=%b exp 1/%h/%h/1", k-1, wb_valid, wb_rc_addr, wb_rc_data, wb_rc_w_valid, exp_idx[k-1], rd[k-1]); else passed++;
            end
            step();
            dm_gnt = 0; dm_rvalid = 1; dm_rdata = rd[k];
            @(negedge clk);
            total++; if ({dm_req, wb_valid} !== 2'b00) $display("FAIL lm_resp_%0d got req=%b wb=%b exp 0/0", k, dm_req, wb_valid); else passed++;
            step();
        end
        dm_rvalid = 0; dm_rdata = 0;
        @(negedge clk);
        total++; if ({wb_valid, wb_opcode, wb_rc_addr, wb_rc_data, wb_rc_w_valid} !== {1'b1, 4'd6, 3'd7, 16'h3333, 1'b1})
            $display("FAIL lm_wb_2 got v=%b op=%h rc=%h d=%h w=%b exp 1/6/7/3333/1", wb_valid, wb_opcode, wb_rc_addr, wb_rc_data, wb_rc_w_valid); else passed++;
        total++; if ({dm_req, in_ready} !== 2'b01) $display("FAIL lm_done got req=%b ready=%b exp 0/1", dm_req, in_ready); else passed++;
        idle_inputs();
        step();
    endtask

    task automatic test_sm();
        logic [2:0]  exp_idx [3];
        logic [15:0] exp_addr [3];
        exp_idx  = '{3'd0, 3'd5, 3'd7};
        exp_addr = '{16'hFFFF, 16'h0000, 16'h0001};
        in_valid = 1; in_opcode = 4'd7; in_addr = 16'hFFFF; in_mask = 8'b1010_0001;
        step();
        in_valid = 0; in_mask = 0; in_addr = 0;
        for (int k = 0; k < 3; k++) begin
            dm_gnt = 1;
            @(negedge clk);
            total++; if ({dm_req, dm_we, dm_addr, sm_rd_addr} !== {1'b1, 1'b1, exp_addr[k], exp_idx[k]})
                $display("FAIL sm_req_%0d got req=%b we=%b addr=%h rd=%h exp 1/1/%h/%h", k, dm_req, dm_we, dm_addr, sm_rd_addr, exp_addr[k], exp_idx[k]); else passed++;
            total++; if (dm_wdata !== (16'hA000 | {13'b0, exp_idx[k]}))
                $display("FAIL sm_wdata_%0d got=%h exp=%h", k, dm_wdata, 16'hA000 | {13'b0, exp_idx[k]}); else passed++;
            total++; if (wb_valid !== 1'b0) $display("FAIL sm_early_wb_%0d got=%0b exp=0", k, wb_valid); else passed++;
            step();
        end
        dm_gnt = 0;
        @(negedge clk);
        total++; if ({wb_valid, wb_opcode, wb_rc_w_valid} !== {1'b1, 4'd7, 1'b0})
            $display("FAIL sm_retire got v=%b op=%h w=%b exp 1/7/0", wb_valid, wb_opcode, wb_rc_w_valid); else passed++;
        total++; if ({dm_req, in_ready, sm_rd_addr} !== {1'b0, 1'b1, 3'd0})
            $display("FAIL sm_done got req=%b ready=%b rd=%h exp 0/1/0", dm_req, in_ready, sm_rd_addr); else passed++;
        step();
        @(negedge clk);
        total++; if (wb_valid !== 1'b0) $display("FAIL sm_single_retire got=%0b exp=0", wb_valid); else passed++;
        idle_inputs();
    endtask

    task automatic test_mask_zero();
        in_valid = 1; in_opcode = 4'd6; in_addr = 16'h0040; in_mask = 8'h00;
        step();
        in_valid = 0;
        @(negedge clk);
        total++; if ({wb_valid, wb_opcode, wb_rc_w_valid} !== {1'b1, 4'd6, 1'b0})
            $display("FAIL mask0_wb got v=%b op=%h w=%b exp 1/6/0", wb_valid, wb_opcode, wb_rc_w_valid); else passed++;
        total++; if ({dm_req, in_ready} !== 2'b01) $display("FAIL mask0_noreq got req=%b ready=%b exp 0/1", dm_req, in_ready); else passed++;
        idle_inputs();
        step();
    endtask

    task automatic test_flush();
        in_valid = 1; flush = 1; in_opcode = 4'd4; in_addr = 16'h0030; in_rc_addr = 3'd1; in_rc_w_valid = 1;
        step();
        idle_inputs();
        @(negedge clk);
        total++; if ({dm_req, wb_valid, in_ready} !== 3'b001)
            $display("FAIL flush_idle got req=%b wb=%b ready=%b exp 0/0/1", dm_req, wb_valid, in_ready); else passed++;
        step();
        // LM over R1,R2 at 0x0100 with flush and a competing ALU op during RESP.
        in_valid = 1; in_opcode = 4'd6; in_addr = 16'h0100; in_mask = 8'b0000_0110;
        step();
        in_mask = 0; in_addr = 0; in_opcode = 4'd1; in_rc_data = 16'hFFFF; in_rc_addr = 3'd6;
        dm_gnt = 1;
        step();
        dm_gnt = 0; flush = 1; dm_rvalid = 1; dm_rdata = 16'h0A0A;
        step();
        flush = 0; dm_rvalid = 0; dm_gnt = 1;
        @(negedge clk);
        total++; if ({wb_valid, wb_rc_addr, wb_rc_data, wb_rc_w_valid} !== {1'b1, 3'd1, 16'h0A0A, 1'b1})
            $display("FAIL flush_lm_wb0 got v=%b rc=%h d=%h w=%b exp 1/1/0A0A/1", wb_valid, wb_rc_addr, wb_rc_data, wb_rc_w_valid); else passed++;
        total++; if ({dm_req, dm_addr} !== {1'b1, 16'h0101})
            $display("FAIL flush_lm_req1 got req=%b addr=%h exp 1/0101", dm_req, dm_addr); else passed++;
        step();
        dm_gnt = 0; dm_rvalid = 1; dm_rdata = 16'h0B0B; in_valid = 0;
        step();
        dm_rvalid = 0;
        @(negedge clk);
        total++; if ({wb_valid, wb_opcode, wb_rc_addr, wb_rc_data} !== {1'b1, 4'd6, 3'd2, 16'h0B0B})
            $display("FAIL flush_lm_wb1 got v=%b op=%h rc=%h d=%h exp 1/6/2/0B0B", wb_valid, wb_opcode, wb_rc_addr, wb_rc_data); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL flush_lm_done got=%0b exp=1", in_ready); else passed++;
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid_lw();
        in_valid = 1; in_opcode = 4'd4; in_addr = 16'h0050; in_rc_addr = 3'd3; in_rc_w_valid = 1;
        step();
        in_valid = 0; dm_gnt = 1;
        step();
        dm_gnt = 0;
        @(negedge clk);
        total++; if ({dm_req, in_ready} !== 2'b00) $display("FAIL rst_lw_in_resp got req=%b ready=%b exp 0/0", dm_req, in_ready); else passed++;
        step();
        rst = 0;
        #1;
        total++; if ({dm_req, in_ready} !== 2'b01) $display("FAIL rst_lw_abort got req=%b ready=%b exp 0/1", dm_req, in_ready); else passed++;
        total++; if ({wb_valid, wb_opcode, wb_rc_addr, wb_rc_data, wb_rc_w_valid} !== '0)
            $display("FAIL rst_lw_wb got=%h exp=0", {wb_valid, wb_opcode, wb_rc_addr, wb_rc_data, wb_rc_w_valid}); else passed++;
        step();
        dm_rvalid = 1; dm_rdata = 16'h7777;
        @(negedge clk);
        rst = 1;
        step();
        step();
        dm_rvalid = 0; dm_rdata = 0;
        @(negedge clk);
        total++; if ({wb_valid, wb_rc_data, dm_req} !== '0)
            $display("FAIL rst_lw_late_rvalid got wb=%b d=%h req=%b exp 0/0/0", wb_valid, wb_rc_data, dm_req); else passed++;
        idle_inputs();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d/%0d checks", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_passthrough();
        test_lw();
        test_sw();
        test_lm_wrap();
        test_sm();
        test_mask_zero();
        test_flush();
        test_reset_mid_lw();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
